// File: rtl/boot_loader.sv
// Byte-stream instruction RAM loader: holds the CPU in reset until a complete image is written.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int width       = 16,
  parameter int iaddr_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [iaddr_width-1:0] iaddr_write,
  output logic [width-1:0]       idata_write,
  output logic                   i_write,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   err
);

  localparam int B  = width / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int D  = 1 << iaddr_width;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WDRAIN, RUN, ERR
`ifdef LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
  logic [7:0] csum;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  state_t                 state, next_state;
  logic [7:0]             len_lo;
  logic [15:0]            n_words;
  logic [15:0]            len_full;
  logic [iaddr_width:0]   wcnt;
  logic [BW-1:0]          bcnt;
  logic [width-1:0]       asm_word, word_next;
  logic                   accept, last_byte, last_word;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = (bcnt == BW'(B - 1));
  assign last_word = ((32'(wcnt) + 32'd1) == 32'(n_words));
  assign len_full  = {rx_data, len_lo};

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CSUM:                 rx_ready = 1'b1;
`endif
      default:              rx_ready = 1'b0;
    endcase
  end

  always_comb begin
    word_next = asm_word;
    word_next[8*bcnt +: 8] = rx_data;
  end

  always_comb begin
    next_state = state;
    if (start) begin
      next_state = LEN_LO;
    end else begin
      case (state)
        LEN_LO: if (accept) next_state = LEN_HI;
        LEN_HI: if (accept) begin
          if (32'(len_full) > D)     next_state = ERR;
          else if (len_full == '0)   next_state = AFTER_DATA;
          else                       next_state = DATA;
        end
        DATA:   if (accept && last_byte && last_word) next_state = WDRAIN;
        WDRAIN: next_state = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
        CSUM:   if (accept) next_state = (rx_data == csum) ? RUN : ERR;
`endif
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Status outputs trail the state by one register; start forces them back immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cpu_reset <= start || (state != RUN);
      done      <= !start && (state == RUN);
      err       <= !start && (state == ERR);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iaddr_write <= '0;
      idata_write <= '0;
      i_write     <= 1'b0;
      len_lo      <= '0;
      n_words     <= '0;
      wcnt        <= '0;
      bcnt        <= '0;
      asm_word    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      i_write <= 1'b0;
      if (start) begin
        iaddr_write <= '0;
        wcnt        <= '0;
        bcnt        <= '0;
        asm_word    <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum        <= '0;
`endif
      end else begin
        // Post-write increment is suppressed after the final word so a full RAM never wraps.
        if (i_write && state == DATA) iaddr_write <= iaddr_write + iaddr_width'(1);
        if (state == LEN_LO && accept) len_lo  <= rx_data;
        if (state == LEN_HI && accept) n_words <= len_full;
        if (state == DATA && accept) begin
          asm_word <= word_next;
`ifdef LOADER_CHECKSUM_EN
          csum     <= csum + rx_data;
`endif
          if (last_byte) begin
            bcnt        <= '0;
            idata_write <= word_next;
            i_write     <= 1'b1;
            wcnt        <= wcnt + (iaddr_width + 1)'(1);
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: images built from the byte-format rules, writes scoreboarded.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_boot_loader;
  localparam int W  = 16;
  localparam int AW = 8;
  localparam int B  = W / 8;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready, i_write, cpu_reset, done, err;
  logic [AW-1:0] iaddr_write;
  logic [W-1:0]  idata_write;

  int errors = 0;
  int checks = 0;
  logic [7:0]      img[$];
  logic [AW+W-1:0] exp_w[$];
  logic [AW+W-1:0] got_w[$];

  always #5 clk = ~clk;

  boot_loader #(.width(W), .iaddr_width(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .iaddr_write(iaddr_write), .idata_write(idata_write),
    .i_write(i_write), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always @(negedge clk) if (i_write) got_w.push_back({iaddr_write, idata_write});

  // Reference image: header, little-endian words, optional 8-bit sum of data bytes.
  function automatic void build_image(input int n, input bit good_sum);
    logic [7:0]   sum;
    logic [W-1:0] w;
    logic [7:0]   b;
    sum = 8'h00;
    img.delete();
    exp_w.delete();
    img.push_back(8'(n % 256));
    img.push_back(8'(n / 256));
    for (int i = 0; i < n; i++) begin
      w = W'($urandom);
      exp_w.push_back({AW'(i), w});
      for (int j = 0; j < B; j++) begin
        b = 8'((w >> (8 * j)) % 256);
        img.push_back(b);
        sum = 8'((int'(sum) + int'(b)) % 256);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    img.push_back(good_sum ? sum : 8'(sum ^ 8'h5A));
`else
    if (good_sum) sum = 8'h00;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent = 0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 40 && !sent; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        sent = 1;
      end
    end
    rx_valid = 1'b0;
    checks++;
    if (!sent) begin
      errors++;
      $display("FAIL send_byte: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
    end
  endtask

  task automatic send_bytes(input int upto);
    for (int i = 0; i < upto; i++) send_byte(img[i]);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_status(input string name, input logic exp_done, input logic exp_err);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || err) break;
    end
    checks++;
    if ({done, err, cpu_reset} !== {exp_done, exp_err, !exp_done}) begin
      errors++;
      $display("FAIL %s: done/err/cpu_reset=%b%b%b required %b%b%b", name, done, err, cpu_reset,
               exp_done, exp_err, !exp_done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string name);
    int bad;
    bad = -1;
    if (got_w.size() == exp_w.size())
      foreach (exp_w[i]) if (bad < 0 && got_w[i] !== exp_w[i]) bad = i;
    checks++;
    if (got_w.size() != exp_w.size()) begin
      errors++;
      $display("FAIL %s: write count %0d required %0d", name, got_w.size(), exp_w.size());
    end else if (bad >= 0) begin
      errors++;
      $display("FAIL %s: write %0d addr/data=%h required %h", name, bad, got_w[bad], exp_w[bad]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++;
    if ({rx_ready, cpu_reset, i_write, done, err, iaddr_write, idata_write} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_values: rdy/cpur/iw/done/err=%b%b%b%b%b addr=%h data=%h required 01000 0 0",
               rx_ready, cpu_reset, i_write, done, err, iaddr_write, idata_write);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, cpu_reset, done} !== 3'b010) begin
      errors++;
      $display("FAIL idle_hold: rx_ready/cpu_reset/done=%b%b%b required 010", rx_ready, cpu_reset, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [7:0] sum;
    img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    exp_w = '{{8'd0, 16'h1234}, {8'd1, 16'h5678}};
    sum = 8'h00;
    for (int i = 2; i < 6; i++) sum = 8'((int'(sum) + int'(img[i])) % 256);
    got_w.delete();
    pulse_start;
    send_bytes(6);
    @(negedge clk);
    checks++;
    if ({i_write, iaddr_write, idata_write, cpu_reset} !== {1'b1, 8'd1, 16'h5678, 1'b1}) begin
      errors++;
      $display("FAIL basic_last_write: iw=%b addr=%h data=%h cpur=%b required 1 01 5678 1",
               i_write, iaddr_write, idata_write, cpu_reset);
    end
    @(negedge clk);
    checks++;
    if ({i_write, cpu_reset} !== 2'b01) begin
      errors++;
      $display("FAIL basic_pulse_end: i_write/cpu_reset=%b%b required 01", i_write, cpu_reset);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum);
    @(negedge clk);
    checks++;
    if (cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL basic_csum_hold: cpu_reset=%b required 1", cpu_reset);
    end
    @(negedge clk);
`else
    @(negedge clk);
`endif
    checks++;
    if ({cpu_reset, done, err} !== 3'b010) begin
      errors++;
      $display("FAIL basic_release: cpu_reset/done/err=%b%b%b required 010", cpu_reset, done, err);
    end
    check_writes("basic_writes");
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_csum;
`ifdef LOADER_CHECKSUM_EN
    build_image(2, 0);
    got_w.delete();
    pulse_start;
    send_bytes(img.size());
    wait_status("bad_csum", 1'b0, 1'b1);
    check_writes("bad_csum_writes");
    build_image(3, 1);
    got_w.delete();
    pulse_start;
    send_bytes(img.size());
    wait_status("bad_csum_recover", 1'b1, 1'b0);
    check_writes("bad_csum_recover_writes");
`endif
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      build_image($urandom_range(1, 12), 1);
      got_w.delete();
      pulse_start;
      send_bytes(img.size());
      wait_status("random_done", 1'b1, 1'b0);
      check_writes("random_writes");
    end
  endtask

  task automatic test_zero_len;
    build_image(0, 1);
    got_w.delete();
    pulse_start;
    send_bytes(img.size());
    wait_status("zero_len", 1'b1, 1'b0);
    check_writes("zero_len_writes");
  endtask

  task automatic test_overlength;
    got_w.delete();
    exp_w.delete();
    pulse_start;
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL overlen_ready: rx_ready=%b required 0", rx_ready);
    end
    @(negedge clk);
    checks++;
    if ({err, cpu_reset, done} !== 3'b110) begin
      errors++;
      $display("FAIL overlen_err: err/cpu_reset/done=%b%b%b required 110", err, cpu_reset, done);
    end
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if ({rx_ready, err} !== 2'b01) begin
      errors++;
      $display("FAIL overlen_sticky: rx_ready/err=%b%b required 01", rx_ready, err);
    end
    check_writes("overlen_writes");
    @(posedge clk);
    #1;
  endtask

  task automatic test_full;
    time t0;
    int  nbytes;
    build_image(D, 1);
    nbytes = 2 + D * B;
    got_w.delete();
    pulse_start;
    t0 = $time;
    send_bytes(nbytes);
    checks++;
    if (($time - t0) != time'(nbytes * 10)) begin
      errors++;
      $display("FAIL full_rate: %0t ns for %0d bytes required %0d ns", $time - t0, nbytes, nbytes * 10);
    end
    for (int i = nbytes; i < img.size(); i++) send_byte(img[i]);
    wait_status("full_done", 1'b1, 1'b0);
    check_writes("full_writes");
  endtask

  task automatic test_restart;
    build_image(10, 1);
    got_w.delete();
    pulse_start;
    send_bytes(2 + 3 * B);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (got_w.size() != 3 || got_w[2] !== exp_w[2]) begin
      errors++;
      $display("FAIL restart_partial: writes=%0d required 3", got_w.size());
    end
    pulse_start;
    @(negedge clk);
    checks++;
    if ({cpu_reset, iaddr_write, done} !== {1'b1, {AW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL restart_clear: cpu_reset=%b addr=%h done=%b required 1 00 0",
               cpu_reset, iaddr_write, done);
    end
    build_image(2, 1);
    img.delete(0);
    img.delete(0);
    got_w.delete();
    @(posedge clk);
    #1;
    pulse_start;
    send_byte(8'h02);
    send_byte(8'h00);
    send_bytes(img.size());
    wait_status("restart_done", 1'b1, 1'b0);
    check_writes("restart_writes");
  endtask

  task automatic test_async_reset;
    build_image(6, 1);
    pulse_start;
    send_bytes(2 + 2 * B + 1);
    got_w.delete();
    exp_w.delete();
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({rx_ready, cpu_reset, i_write} !== 3'b010) begin
      errors++;
      $display("FAIL async_reset: rx_ready/cpu_reset/i_write=%b%b%b required 010",
               rx_ready, cpu_reset, i_write);
    end
    #20;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({rx_ready, cpu_reset, done} !== 3'b010) begin
      errors++;
      $display("FAIL async_idle: rx_ready/cpu_reset/done=%b%b%b required 010", rx_ready, cpu_reset, done);
    end
    rx_valid = 1'b0;
    check_writes("async_no_writes");
    @(posedge clk);
    #1;
    build_image(3, 1);
    got_w.delete();
    pulse_start;
    send_bytes(img.size());
    wait_status("async_recover", 1'b1, 1'b0);
    check_writes("async_recover_writes");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_csum;
    test_random;
    test_zero_len;
    test_overlength;
    test_full;
    test_restart;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
